u3v_frame_sequencer: RTL and testbench
======================================

Name: u3v_frame_sequencer

Overview:
- Per-frame phase controller for the U3V stream path.
- Sequences LEADER -> IMAGE -> CHUNK -> TRAILER phase flags that feed the payload assembler and the leader/trailer generators.
- Latches the per-frame timestamp, owns the 64-bit block ID counter, snapshots the chunk enables at frame start, and counts frames dropped while busy.

Parameters:
- LEADER_CYCLES, 8, number of clk cycles o_leader_flag is held high.
- CHUNK_CYCLES, 10, number of clk cycles o_chunk_flag is held high (one per chunk word).
- TRAILER_CYCLES, 8, number of clk cycles o_trailer_flag is held high.
- GAP_CYCLES, 4, idle cycles between TRAILER end and acceptance of the next frame.
- TIMEOUT_CYCLES, 32'd50_000_000, IMAGE-phase watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_stream_enable  in  1  stream enable; rising edge clears block ID
- i_frame_start  in  1  one-cycle pulse, upstream frame begins
- i_frame_end  in  1  one-cycle pulse, last image word delivered
- i_chunk_mode_active  in  1  chunk master enable
- iv_timestamp_live  in  64  free-running timestamp
- o_leader_flag  out  1  leader phase
- o_image_flag  out  1  image phase
- o_chunk_flag  out  1  chunk phase
- o_trailer_flag  out  1  trailer phase
- o_busy  out  1  high in any state other than IDLE
- ov_blockid  out  64  block ID of current/last frame
- ov_timestamp  out  64  timestamp latched at frame start
- ov_drop_cnt  out  16  frame starts ignored while busy, saturating
- o_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset values: all flags 0, o_busy 0, ov_blockid 0, ov_timestamp 0, ov_drop_cnt 0, o_timeout 0, state IDLE.
- Reset mid-frame returns to IDLE on the next clock and all flags drop.
- States: IDLE, LEADER, IMAGE, CHUNK, TRAILER, GAP.
- IDLE -> LEADER: on i_frame_start && stream_en_q (i_stream_enable registered once).
  - Same edge latches ov_timestamp <= iv_timestamp_live and chunk_en_q <= i_chunk_mode_active.
- Flags are registered and equal to the state decode, so each flag rises 1 cycle after the causing edge.
- LEADER: phase counter runs 0..LEADER_CYCLES-1, then -> IMAGE.
- IMAGE: o_image_flag high until an i_frame_end sample, then next state is CHUNK if chunk_en_q, else TRAILER.
  - i_frame_end in the same cycle as LEADER's last cycle is ignored. Upstream guarantees frame_end comes after image start.
- CHUNK: exactly CHUNK_CYCLES cycles of o_chunk_flag, continuous with no gaps, then -> TRAILER.
- TRAILER: TRAILER_CYCLES cycles, then -> GAP.
  - On the final TRAILER cycle, ov_blockid increments by 1 (64-bit wrap to 0).
- GAP: GAP_CYCLES cycles, then -> IDLE.
- Exactly one phase flag is high at a time. No zero-length phases: a parameter value of 0 is treated as 1.
- Block ID clear: the stream_en_q rising edge (01 detect) clears ov_blockid to 0. An increment on the same cycle loses to the clear.
- Frame drop: i_frame_start while state != IDLE, or while stream_en_q == 0, increments ov_drop_cnt. The counter saturates at 16'hFFFF.
- Stream disable mid-frame: the current frame completes through GAP. Only the next start is blocked.
- Phase counter width is 32 bits and resets to 0 on every state change.

Optional Feature:
- Macro: U3V_SEQ_TIMEOUT_EN.
- Defined:
  - A 32-bit counter runs during IMAGE.
  - At TIMEOUT_CYCLES without i_frame_end, the sequencer forces the transition out of IMAGE as if i_frame_end had arrived, and sets o_timeout = 1.
  - o_timeout is sticky; only reset or a stream_en_q rising edge clears it.
- Undefined:
  - IMAGE waits indefinitely for i_frame_end.
  - o_timeout is constant 0 and no counter logic is built.

Test Plan:
1. Reset, enable stream, pulse frame_start at cycle 10 with chunk_mode=1 and frame_end 100 cycles after image starts -> leader 8 cycles, image 100, chunk exactly 10, trailer 8. ov_blockid becomes 1 at trailer end.
2. Same frame with chunk_mode=0 -> no chunk_flag cycles; IMAGE goes directly to TRAILER. Toggling chunk_mode mid-frame does not change the current frame.
3. frame_start pulsed during IMAGE and during GAP -> ov_drop_cnt = 2 and the current frame's sequence is unaffected.
4. Three frames, then stream_enable 1->0->1 -> ov_blockid 3 then 0; frame_start while disabled increments ov_drop_cnt.
5. Reset asserted mid-CHUNK -> next cycle all flags 0, o_busy 0, ov_blockid 0; a subsequent frame runs normally.
6. With U3V_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=50, no frame_end -> image flag lasts exactly 50 cycles, o_timeout=1 and stays 1 through the next frame.

Source files
------------

// File: rtl/u3v_frame_sequencer.sv
// u3v_frame_sequencer: per-frame phase controller for the U3V stream path.
// Walks IDLE -> LEADER -> IMAGE -> [CHUNK] -> TRAILER -> GAP and drives one
// phase flag at a time toward the payload assembler and leader/trailer
// generators. Latches the frame timestamp and chunk enable at frame start,
// owns the 64-bit block ID and counts frame starts dropped while busy.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   i_stream_enable        stream enable (registered; rising edge clears block ID)
//   i_frame_start          one-cycle pulse, upstream frame begins
//   i_frame_end            one-cycle pulse, last image word delivered
//   i_chunk_mode_active    chunk master enable, snapshotted at frame start
//   iv_timestamp_live      free-running 64-bit timestamp
//   o_leader_flag/o_image_flag/o_chunk_flag/o_trailer_flag  phase flags
//   o_busy                 high in any state other than IDLE
//   ov_blockid             block ID of current/last frame
//   ov_timestamp           timestamp latched at frame start
//   ov_drop_cnt            saturating count of ignored frame starts
//   o_timeout              sticky IMAGE watchdog flag
//
// Optional feature macro: U3V_SEQ_TIMEOUT_EN enables the IMAGE watchdog.
// Without it o_timeout is tied to 0 and no watchdog counter is built.

module u3v_frame_sequencer #(
  parameter int unsigned LEADER_CYCLES  = 8,
  parameter int unsigned CHUNK_CYCLES   = 10,
  parameter int unsigned TRAILER_CYCLES = 8,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stream_enable,
  input  logic        i_frame_start,
  input  logic        i_frame_end,
  input  logic        i_chunk_mode_active,
  input  logic [63:0] iv_timestamp_live,
  output logic        o_leader_flag,
  output logic        o_image_flag,
  output logic        o_chunk_flag,
  output logic        o_trailer_flag,
  output logic        o_busy,
  output logic [63:0] ov_blockid,
  output logic [63:0] ov_timestamp,
  output logic [15:0] ov_drop_cnt,
  output logic        o_timeout
);

  // Zero-length phases are not allowed: a 0 parameter behaves as 1.
  localparam int unsigned LEADER_EFF  = (LEADER_CYCLES  == 0) ? 1 : LEADER_CYCLES;
  localparam int unsigned CHUNK_EFF   = (CHUNK_CYCLES   == 0) ? 1 : CHUNK_CYCLES;
  localparam int unsigned TRAILER_EFF = (TRAILER_CYCLES == 0) ? 1 : TRAILER_CYCLES;
  localparam int unsigned GAP_EFF     = (GAP_CYCLES     == 0) ? 1 : GAP_CYCLES;

  localparam logic [31:0] LEADER_LAST  = 32'(LEADER_EFF - 1);
  localparam logic [31:0] CHUNK_LAST   = 32'(CHUNK_EFF - 1);
  localparam logic [31:0] TRAILER_LAST = 32'(TRAILER_EFF - 1);
  localparam logic [31:0] GAP_LAST     = 32'(GAP_EFF - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEADER,
    ST_IMAGE,
    ST_CHUNK,
    ST_TRAILER,
    ST_GAP
  } state_t;

  state_t      state;
  logic [31:0] phase_cnt;
  logic        stream_en_q;
  logic        stream_en_qq;
  logic        chunk_en_q;
  logic        en_rise_c;
  logic        image_done_c;

  assign en_rise_c = stream_en_q & ~stream_en_qq;

`ifdef U3V_SEQ_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 32'd0) ? 32'd0
                                                                   : TIMEOUT_CYCLES - 32'd1;
  logic [31:0] wdog_cnt;
  logic        wdog_hit_c;

  assign wdog_hit_c   = (state == ST_IMAGE) && (wdog_cnt == TIMEOUT_LAST);
  assign image_done_c = i_frame_end | wdog_hit_c;

  // Watchdog: counts IMAGE cycles from 0 on entry; sticky flag on expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt  <= '0;
      o_timeout <= 1'b0;
    end else begin
      wdog_cnt <= (state == ST_IMAGE) ? wdog_cnt + 32'd1 : 32'd0;
      if (en_rise_c)
        o_timeout <= 1'b0;
      else if (wdog_hit_c && !i_frame_end)
        o_timeout <= 1'b1;
    end
  end
`else
  assign image_done_c = i_frame_end;
  assign o_timeout    = 1'b0;
`endif

  // Phase FSM; flags and busy are registered alongside each state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      phase_cnt      <= '0;
      stream_en_q    <= 1'b0;
      stream_en_qq   <= 1'b0;
      chunk_en_q     <= 1'b0;
      o_leader_flag  <= 1'b0;
      o_image_flag   <= 1'b0;
      o_chunk_flag   <= 1'b0;
      o_trailer_flag <= 1'b0;
      o_busy         <= 1'b0;
      ov_blockid     <= '0;
      ov_timestamp   <= '0;
      ov_drop_cnt    <= '0;
    end else begin
      stream_en_q  <= i_stream_enable;
      stream_en_qq <= stream_en_q;

      // Starts that cannot be accepted are counted, saturating.
      if (i_frame_start && (state != ST_IDLE || !stream_en_q) && ov_drop_cnt != 16'hFFFF)
        ov_drop_cnt <= ov_drop_cnt + 16'd1;

      if (en_rise_c)
        ov_blockid <= '0;

      case (state)
        ST_IDLE: begin
          if (i_frame_start && stream_en_q) begin
            state         <= ST_LEADER;
            phase_cnt     <= '0;
            ov_timestamp  <= iv_timestamp_live;
            chunk_en_q    <= i_chunk_mode_active;
            o_leader_flag <= 1'b1;
            o_busy        <= 1'b1;
          end
        end
        ST_LEADER: begin
          if (phase_cnt == LEADER_LAST) begin
            state         <= ST_IMAGE;
            phase_cnt     <= '0;
            o_leader_flag <= 1'b0;
            o_image_flag  <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        ST_IMAGE: begin
          if (image_done_c) begin
            phase_cnt    <= '0;
            o_image_flag <= 1'b0;
            if (chunk_en_q) begin
              state        <= ST_CHUNK;
              o_chunk_flag <= 1'b1;
            end else begin
              state          <= ST_TRAILER;
              o_trailer_flag <= 1'b1;
            end
          end
        end
        ST_CHUNK: begin
          if (phase_cnt == CHUNK_LAST) begin
            state          <= ST_TRAILER;
            phase_cnt      <= '0;
            o_chunk_flag   <= 1'b0;
            o_trailer_flag <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        ST_TRAILER: begin
          if (phase_cnt == TRAILER_LAST) begin
            state          <= ST_GAP;
            phase_cnt      <= '0;
            o_trailer_flag <= 1'b0;
            // A coincident enable rising edge wins over the increment.
            if (!en_rise_c)
              ov_blockid <= ov_blockid + 64'd1;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        ST_GAP: begin
          if (phase_cnt == GAP_LAST) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            o_busy    <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        default: begin
          state          <= ST_IDLE;
          phase_cnt      <= '0;
          o_leader_flag  <= 1'b0;
          o_image_flag   <= 1'b0;
          o_chunk_flag   <= 1'b0;
          o_trailer_flag <= 1'b0;
          o_busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_u3v_frame_sequencer.sv
// tb_u3v_frame_sequencer: self-checking bench for u3v_frame_sequencer.
// A negedge monitor turns the flag/busy outputs into phase runs {phase, length};
// each frame pushes its expected runs to a queue and they are popped and
// compared once the frame returns to IDLE.

module tb_u3v_frame_sequencer;

  localparam int unsigned LEAD = 8;
  localparam int unsigned CHK  = 10;
  localparam int unsigned TRL  = 8;
  localparam int unsigned GAPC = 4;
  localparam int unsigned TMO  = 50;

  // Phase codes as seen by the monitor.
  localparam int P_IDLE = 0, P_LEAD = 1, P_IMG = 2, P_CHK = 3, P_TRL = 4, P_GAP = 5, P_BAD = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_stream_enable;
  logic        i_frame_start;
  logic        i_frame_end;
  logic        i_chunk_mode_active;
  logic [63:0] iv_timestamp_live;
  logic        o_leader_flag;
  logic        o_image_flag;
  logic        o_chunk_flag;
  logic        o_trailer_flag;
  logic        o_busy;
  logic [63:0] ov_blockid;
  logic [63:0] ov_timestamp;
  logic [15:0] ov_drop_cnt;
  logic        o_timeout;

  always #5 clk = ~clk;

  u3v_frame_sequencer #(
    .LEADER_CYCLES (LEAD),
    .CHUNK_CYCLES  (CHK),
    .TRAILER_CYCLES(TRL),
    .GAP_CYCLES    (GAPC),
    .TIMEOUT_CYCLES(32'(TMO))
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .i_stream_enable    (i_stream_enable),
    .i_frame_start      (i_frame_start),
    .i_frame_end        (i_frame_end),
    .i_chunk_mode_active(i_chunk_mode_active),
    .iv_timestamp_live  (iv_timestamp_live),
    .o_leader_flag      (o_leader_flag),
    .o_image_flag       (o_image_flag),
    .o_chunk_flag       (o_chunk_flag),
    .o_trailer_flag     (o_trailer_flag),
    .o_busy             (o_busy),
    .ov_blockid         (ov_blockid),
    .ov_timestamp       (ov_timestamp),
    .ov_drop_cnt        (ov_drop_cnt),
    .o_timeout          (o_timeout)
  );

  typedef struct {
    int code;
    int len;
  } run_t;

  typedef struct {
    logic        chunk;
    int          img_len;
    logic        toggle;
    logic        drop_img;
    logic        drop_gap;
    logic        no_end;
    logic [63:0] exp_bid;
    logic [15:0] exp_drop;
  } frame_vec_t;

  run_t exp_q[$];
  run_t obs_q[$];
  int   checks   = 0;
  int   passes   = 0;
  int   bad_cnt  = 0;
  int   cur_code = 0;
  int   cur_len  = 0;

  function automatic int phase_code();
    int n;
    n = 32'(o_leader_flag) + 32'(o_image_flag) + 32'(o_chunk_flag) + 32'(o_trailer_flag);
    if (n > 1 || (n == 1 && !o_busy)) return P_BAD;
    if (o_leader_flag)  return P_LEAD;
    if (o_image_flag)   return P_IMG;
    if (o_chunk_flag)   return P_CHK;
    if (o_trailer_flag) return P_TRL;
    if (o_busy)         return P_GAP;
    return P_IDLE;
  endfunction

  // Run-length monitor of the phase outputs.
  always @(negedge clk) begin
    int c;
    if (reset) begin
      cur_code = P_IDLE;
      cur_len  = 0;
    end else begin
      c = phase_code();
      if (c == P_BAD) bad_cnt++;
      if (c == cur_code) begin
        cur_len++;
      end else begin
        if (cur_code != P_IDLE) obs_q.push_back('{cur_code, cur_len});
        cur_code = c;
        cur_len  = 1;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return o_busy;
      1:       return o_image_flag;
      2:       return o_trailer_flag;
      default: return o_chunk_flag;
    endcase
  endfunction

  // Bounded wait at negedges for a DUT output to reach a value.
  task automatic wait_sig(input int sel, input logic val, input int budget, input string nm);
    int   n;
    logic s;
    n = 0;
    @(negedge clk);
    s = sig(sel);
    while (s !== val && n < budget) begin
      @(negedge clk);
      s = sig(sel);
      n++;
    end
    check({"wait ", nm}, 64'(s), 64'(val));
  endtask

  task automatic compare_runs();
    run_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      else o = '{-1, -1};
      check("phase run {code,len}", {32'(o.code), 32'(o.len)}, {32'(e.code), 32'(e.len)});
    end
    check("extra phase runs", 64'(obs_q.size()), 64'd0);
    obs_q.delete();
  endtask

  task automatic run_frame(input frame_vec_t v);
    logic [63:0] ts;
    ts = {$urandom, $urandom};
    iv_timestamp_live   = ts;
    i_chunk_mode_active = v.chunk;
    i_frame_start       = 1'b1;
    tick();
    i_frame_start     = 1'b0;
    iv_timestamp_live = ~ts;
    exp_q.push_back('{P_LEAD, LEAD});
    exp_q.push_back('{P_IMG, v.img_len});
    if (v.chunk) exp_q.push_back('{P_CHK, CHK});
    exp_q.push_back('{P_TRL, TRL});
    exp_q.push_back('{P_GAP, GAPC});

    wait_sig(1, 1'b1, LEAD + 2, "image start");
    check("blockid during image", ov_blockid, v.exp_bid - 64'd1);
    if (v.toggle) i_chunk_mode_active = ~v.chunk;
    for (int i = 0; i < v.img_len - 1; i++) begin
      i_frame_start = v.drop_img && (i == 1);
      tick();
    end
    i_frame_start = 1'b0;
    i_frame_end   = !v.no_end;
    tick();
    i_frame_end = 1'b0;

    wait_sig(2, 1'b1, CHK + 2, "trailer start");
    wait_sig(2, 1'b0, TRL + 2, "trailer end");
    if (v.drop_gap) begin
      i_frame_start = 1'b1;
      tick();
      i_frame_start = 1'b0;
    end
    wait_sig(0, 1'b0, GAPC + 2, "idle");
    tick();

    compare_runs();
    check("blockid after frame", ov_blockid, v.exp_bid);
    check("timestamp latched", ov_timestamp, ts);
    check("drop count", 64'(ov_drop_cnt), 64'(v.exp_drop));
  endtask

  frame_vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL global time limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    // chunk, img_len, toggle, drop_img, drop_gap, no_end, exp_bid, exp_drop
    vecs[0] = '{1'b1, 100, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, 16'd0};
    vecs[1] = '{1'b0, 100, 1'b1, 1'b0, 1'b0, 1'b0, 64'd2, 16'd0};
    vecs[2] = '{1'b1, 3,   1'b1, 1'b0, 1'b0, 1'b0, 64'd3, 16'd0};
    vecs[3] = '{1'b0, 20,  1'b0, 1'b1, 1'b1, 1'b0, 64'd4, 16'd2};

    reset               = 1'b1;
    i_stream_enable     = 1'b0;
    i_frame_start       = 1'b0;
    i_frame_end         = 1'b0;
    i_chunk_mode_active = 1'b0;
    iv_timestamp_live   = 64'h0123_4567_89AB_CDEF;
    repeat (3) tick();
    check("reset flags", 64'({o_leader_flag, o_image_flag, o_chunk_flag, o_trailer_flag}), 64'd0);
    check("reset busy", 64'(o_busy), 64'd0);
    check("reset blockid", ov_blockid, 64'd0);
    check("reset timestamp", ov_timestamp, 64'd0);
    check("reset drop", 64'(ov_drop_cnt), 64'd0);
    check("reset timeout", 64'(o_timeout), 64'd0);

    reset           = 1'b0;
    i_stream_enable = 1'b1;
    repeat (6) tick();

    for (int k = 0; k < 4; k++) run_frame(vecs[k]);

    // Disable blocks the next start and counts it; re-enable clears block ID.
    i_stream_enable = 1'b0;
    tick();
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    tick();
    check("busy while disabled", 64'(o_busy), 64'd0);
    check("drop while disabled", 64'(ov_drop_cnt), 64'd3);
    check("blockid kept on disable", ov_blockid, 64'd4);
    i_stream_enable = 1'b1;
    tick();
    tick();
    check("blockid cleared on enable", ov_blockid, 64'd0);
    run_frame('{1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, 16'd3});

    // Reset in the middle of CHUNK.
    i_chunk_mode_active = 1'b1;
    i_frame_start       = 1'b1;
    tick();
    i_frame_start = 1'b0;
    wait_sig(1, 1'b1, LEAD + 2, "image start (reset case)");
    repeat (4) tick();
    i_frame_end = 1'b1;
    tick();
    i_frame_end = 1'b0;
    wait_sig(3, 1'b1, 4, "chunk start (reset case)");
    repeat (3) tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("flags after mid-chunk reset",
          64'({o_leader_flag, o_image_flag, o_chunk_flag, o_trailer_flag}), 64'd0);
    check("busy after mid-chunk reset", 64'(o_busy), 64'd0);
    check("blockid after mid-chunk reset", ov_blockid, 64'd0);
    check("drop after mid-chunk reset", 64'(ov_drop_cnt), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    repeat (3) tick();
    run_frame('{1'b1, 12, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, 16'd0});
    check("timeout idle", 64'(o_timeout), 64'd0);

`ifdef U3V_SEQ_TIMEOUT_EN
    run_frame('{1'b0, int'(TMO), 1'b0, 1'b0, 1'b0, 1'b1, 64'd2, 16'd0});
    check("timeout set", 64'(o_timeout), 64'd1);
    run_frame('{1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 64'd3, 16'd0});
    check("timeout sticky", 64'(o_timeout), 64'd1);
`endif

    check("one-hot phase violations", 64'(bad_cnt), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
